decode_24: RTL and testbench



---
 rtl/decode_24_if.sv | 37 +++
 rtl/decode_24.sv | 73 +++++++
 tb/tb_decode_24.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/decode_24_if.sv
// decode_24_if: signal bundle between the control/ALU side and the next-PC unit.
//
// Signals:
//   CurrentPC    [63:0]  address of the instruction being executed
//   SignExtImm64 [63:0]  sign-extended branch offset in instruction words
//   Branch               conditional branch (CBZ) control
//   ALUZero              ALU zero flag
//   Uncondbranch         unconditional branch (B) control
//   NextPC       [63:0]  combinational next fetch address
//   BranchTaken          1 when NextPC is the branch target
//   PCReg        [63:0]  registered NextPC (current fetch address)
//   TakenCount   [31:0]  saturating count of taken branches
//
// Modports:
//   master  drives the controls/operands and observes the results
//   slave   the next-PC unit itself
interface decode_24_if;
    logic [63:0] CurrentPC;
    logic [63:0] SignExtImm64;
    logic        Branch;
    logic        ALUZero;
    logic        Uncondbranch;
    logic [63:0] NextPC;
    logic        BranchTaken;
    logic [63:0] PCReg;
    logic [31:0] TakenCount;

    modport master (
        output CurrentPC, SignExtImm64, Branch, ALUZero, Uncondbranch,
        input  NextPC, BranchTaken, PCReg, TakenCount
    );

    modport slave (
        input  CurrentPC, SignExtImm64, Branch, ALUZero, Uncondbranch,
        output NextPC, BranchTaken, PCReg, TakenCount
    );
endinterface

// File: rtl/decode_24.sv
// decode_24: next-PC computation and PC register for the 64-bit single-cycle
// LEGv8 datapath.
//
// NextPC = Taken ? CurrentPC + (SignExtImm64 << 2) : CurrentPC + 4, where
// Taken = Uncondbranch | (Branch & ALUZero). All additions wrap modulo 2^64.
// NextPC/BranchTaken are purely combinational; PCReg holds NextPC after each
// rising CLK edge (RESET_PC under reset).
//
// Ports:
//   CLK    system clock, rising edge
//   Reset  synchronous, active-high reset
//   bus    decode_24_if.slave (operands, controls, NextPC, BranchTaken,
//          PCReg, TakenCount)
//
// Parameters:
//   RESET_PC  value loaded into PCReg by reset
//
// Build option:
//   DECODE24_STATS_EN  when defined, TakenCount is a saturating 32-bit count
//                      of taken branches; otherwise it is tied to 0.
module decode_24 #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    decode_24_if.slave  bus
);

    logic        taken;
    logic [63:0] target;
    logic [63:0] sequential;
    logic [63:0] next_pc;
    logic [63:0] pc_reg;

    always_comb begin
        taken      = bus.Uncondbranch | (bus.Branch & bus.ALUZero);
        // Word offset to byte offset; the top two bits fall off.
        target     = bus.CurrentPC + {bus.SignExtImm64[61:0], 2'b00};
        sequential = bus.CurrentPC + 64'd4;
        next_pc    = taken ? target : sequential;
    end

    assign bus.NextPC      = next_pc;
    assign bus.BranchTaken = taken;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= next_pc;
        end
    end

    assign bus.PCReg = pc_reg;

`ifdef DECODE24_STATS_EN
    logic [31:0] taken_count;

    // Holds at all-ones instead of wrapping back to zero.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            taken_count <= '0;
        end else if (taken && (taken_count != '1)) begin
            taken_count <= taken_count + 32'd1;
        end
    end

    assign bus.TakenCount = taken_count;
`else
    assign bus.TakenCount = '0;
`endif

endmodule

// File: tb/tb_decode_24.sv
// tb_decode_24: self-checking bench for decode_24. Directed cases from the
// block's intended use, then randomized operands/controls compared against a
// behavioural model of the next-PC rules and the PC/counter registers.
module tb_decode_24;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic CLK = 1'b0;
    logic Reset;

    decode_24_if bus ();

    decode_24 #(.RESET_PC(RESET_PC)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state for the registered outputs.
    logic [63:0] m_pc;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] model_next(input logic [63:0] cur,
                                               input logic [63:0] imm,
                                               input logic b, input logic z,
                                               input logic u);
        if (u || (b && z)) return cur + imm * 64'd4;
        return cur + 64'd4;
    endfunction

    function automatic logic [31:0] expected_count();
`ifdef DECODE24_STATS_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    // Apply one cycle of inputs, check combinational outputs, clock, then
    // check the registered outputs against the model.
    task automatic step(input string tag, input logic rst,
                        input logic [63:0] cur, input logic [63:0] imm,
                        input logic b, input logic z, input logic u);
        logic [63:0] exp_next;
        logic        exp_taken;
        Reset            = rst;
        bus.CurrentPC    = cur;
        bus.SignExtImm64 = imm;
        bus.Branch       = b;
        bus.ALUZero      = z;
        bus.Uncondbranch = u;
        exp_taken = u | (b & z);
        exp_next  = model_next(cur, imm, b, z, u);
        #1;
        check({tag, ".next"},  bus.NextPC, exp_next);
        check({tag, ".taken"}, {63'd0, bus.BranchTaken}, {63'd0, exp_taken});
        @(posedge CLK);
        if (rst) begin
            m_pc  = RESET_PC;
            m_cnt = 32'd0;
        end else begin
            m_pc = exp_next;
            if (exp_taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        #1;
        check({tag, ".pcreg"}, bus.PCReg, m_pc);
        check({tag, ".count"}, {32'd0, bus.TakenCount}, {32'd0, expected_count()});
    endtask

    initial begin
        logic [63:0] cur;
        logic [63:0] imm;
        logic        b, z, u, r;

        Reset = 1'b1;
        bus.CurrentPC = '0;
        bus.SignExtImm64 = '0;
        bus.Branch = 1'b0;
        bus.ALUZero = 1'b0;
        bus.Uncondbranch = 1'b0;
        m_pc = RESET_PC;
        m_cnt = '0;
        #2;

        step("reset", 1'b1, 64'h100, 64'h10, 1'b0, 1'b0, 1'b0);
        check("reset_pc_const", bus.PCReg, 64'h0);

        // Directed next-PC cases.
        step("seq",       1'b0, 64'h100, 64'h10, 1'b0, 1'b0, 1'b0);
        check("seq_const", bus.PCReg, 64'h104);
        step("cbz_taken", 1'b0, 64'h100, 64'h10, 1'b1, 1'b1, 1'b0);
        check("cbz_const", bus.PCReg, 64'h140);
        step("cbz_nz",    1'b0, 64'h100, 64'h10, 1'b1, 1'b0, 1'b0);
        step("zero_only", 1'b0, 64'h100, 64'h10, 1'b0, 1'b1, 1'b0);
        step("b_back",    1'b0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        check("b_back_const", bus.PCReg, 64'hF8);
        step("b_prio",    1'b0, 64'h200, 64'h3, 1'b1, 1'b0, 1'b1);
        step("wrap",      1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5, 1'b0, 1'b0, 1'b0);
        check("wrap_const", bus.PCReg, 64'h0);
        step("self_loop", 1'b0, 64'h400, 64'h0, 1'b0, 1'b0, 1'b1);
        check("self_loop_const", bus.PCReg, 64'h400);

        // Reset, then three unconditional +1-word branches following PCReg.
        step("rst_seq", 1'b1, 64'h0, 64'h1, 1'b0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            step("run_seq", 1'b0, bus.PCReg, 64'h1, 1'b0, 1'b0, 1'b1);
        end
        check("run_seq_pc", bus.PCReg, 64'd12);
`ifdef DECODE24_STATS_EN
        check("run_seq_cnt", {32'd0, bus.TakenCount}, 64'd3);
`else
        check("run_seq_cnt", {32'd0, bus.TakenCount}, 64'd0);
`endif

        // Reset wins over a taken branch on the same edge.
        step("rst_vs_b", 1'b1, 64'h1000, 64'h40, 1'b0, 1'b0, 1'b1);
        check("rst_vs_b_cnt", {32'd0, bus.TakenCount}, 64'd0);

        // Randomized traffic.
        for (int unsigned i = 0; i < 300; i++) begin
            b = 1'($urandom);
            z = 1'($urandom);
            u = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0: imm = {$urandom, $urandom};
                1: imm = {{48{1'b1}}, 16'($urandom)};
                default: imm = {48'd0, 16'($urandom)};
            endcase
            if ($urandom_range(0, 1) == 0) cur = m_pc;
            else cur = {$urandom, $urandom};
            step("rand", r, cur, imm, b, z, u);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
